// File: rtl/p4_tuple_packet_sync_pkg.sv
// Shared defaults, FSM state type and skid-entry layout for the tuple/packet sync block.
package p4_sync_pkg;

    localparam int DEF_DATA_W      = 256;
    localparam int DEF_TUPLE_W     = 128;
    localparam int DEF_TUPLE_DEPTH = 8;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    // Skid entry layout at the default widths; the top re-declares the same
    // field order at its own parameter widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0]   tdata;
        logic [DEF_DATA_W/8-1:0] tkeep;
        logic                    tlast;
        logic                    sop;
        logic [DEF_TUPLE_W-1:0]  tuple;
    } skid_entry_t;

endpackage

// File: rtl/p4_tuple_packet_sync_if.sv
// AXI-Stream bundle used for both the packet input and packet output ports.
interface p4_tuple_packet_sync_if
    import p4_sync_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_W-1:0]     TDATA;
    logic [DATA_W/8-1:0]   TKEEP;
    logic                  TLAST;

    modport master (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);
endinterface

// File: rtl/p4_tuple_packet_sync_fifo.sv
// Single-clock FIFO with occupancy output; push and pop on a full FIFO both succeed.
module p4_tuple_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             wr_en;
    logic             rd_en;

    assign full     = (level_reg == (AW+1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    // Combinational head read: a tuple is usable the cycle after it is written.
    assign pop_data = mem[rd_ptr_reg];

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: rtl/p4_tuple_packet_sync.sv
// Pairs each incoming packet with a buffered tuple and re-emits the tuple on the output SOP.
module p4_tuple_packet_sync
    import p4_sync_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TUPLE_W     = DEF_TUPLE_W,
    parameter int TUPLE_DEPTH = DEF_TUPLE_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                          clk_line,
    input  logic                          clk_line_rst,
    input  logic                          enable_processing,
    p4_tuple_packet_sync_if.slave         packet_in,
    p4_tuple_packet_sync_if.master        packet_out,
    input  logic                          tuple_in_VALID,
    input  logic [TUPLE_W-1:0]            tuple_in_DATA,
    output logic                          tuple_out_VALID,
    output logic [TUPLE_W-1:0]            tuple_out_DATA,
    output logic [CNT_W-1:0]              pkt_count,
    output logic [CNT_W-1:0]              tuple_drop_count,
    output logic [$clog2(TUPLE_DEPTH):0]  tuple_fifo_level
);
    typedef struct packed {
        logic [DATA_W-1:0]   tdata;
        logic [DATA_W/8-1:0] tkeep;
        logic                tlast;
        logic                sop;
        logic [TUPLE_W-1:0]  tuple;
    } beat_t;

    state_t              state_reg;
    logic [TUPLE_W-1:0]  cur_tuple_reg;
    beat_t               head_reg;
    beat_t               tail_reg;
    logic                head_valid_reg;
    logic                tail_valid_reg;
    logic [CNT_W-1:0]    pkt_count_reg;
    logic [CNT_W-1:0]    drop_count_reg;

    logic                fifo_full;
    logic                fifo_empty;
    logic [TUPLE_W-1:0]  fifo_head;
    logic                fifo_pop;
    logic                in_ready;
    logic                in_push;
    logic                out_pop;
    beat_t               new_beat;

    p4_tuple_fifo #(
        .WIDTH (TUPLE_W),
        .DEPTH (TUPLE_DEPTH)
    ) u_tuple_fifo (
        .clk       (clk_line),
        .rst_n     (clk_line_rst),
        .push      (tuple_in_VALID),
        .push_data (tuple_in_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (tuple_fifo_level)
    );

    // Ready uses only registered state plus the enable; the output ready never feeds back here.
    assign in_ready = !tail_valid_reg &&
                      ((state_reg == IN_PKT) || (enable_processing && !fifo_empty));
    assign in_push  = packet_in.TVALID && in_ready;
    assign fifo_pop = in_push && (state_reg == IDLE);
    assign out_pop  = head_valid_reg && packet_out.TREADY;

    // Non-SOP beats carry the packet's tuple too, so the head register always holds
    // the tuple of the most recently presented packet.
    assign new_beat.tdata = packet_in.TDATA;
    assign new_beat.tkeep = packet_in.TKEEP;
    assign new_beat.tlast = packet_in.TLAST;
    assign new_beat.sop   = (state_reg == IDLE);
    assign new_beat.tuple = (state_reg == IDLE) ? fifo_head : cur_tuple_reg;

    assign packet_in.TREADY  = in_ready;
    assign packet_out.TVALID = head_valid_reg;
    assign packet_out.TDATA  = head_reg.tdata;
    assign packet_out.TKEEP  = head_reg.tkeep;
    assign packet_out.TLAST  = head_reg.tlast;
    assign tuple_out_VALID   = out_pop && head_reg.sop;
    assign tuple_out_DATA    = head_reg.tuple;
    assign pkt_count         = pkt_count_reg;
    assign tuple_drop_count  = drop_count_reg;

    // Input FSM: SOP admission latches the popped tuple; TLAST returns to IDLE.
    always_ff @(posedge clk_line or negedge clk_line_rst) begin
        if (!clk_line_rst) begin
            state_reg     <= IDLE;
            cur_tuple_reg <= '0;
        end else if (in_push) begin
            if (state_reg == IDLE) begin
                cur_tuple_reg <= fifo_head;
                state_reg     <= packet_in.TLAST ? IDLE : IN_PKT;
            end else if (packet_in.TLAST) begin
                state_reg <= IDLE;
            end
        end
    end

    // Two-entry skid buffer; the head entry drives the output directly.
    // A push is impossible while the tail is occupied, so the pop-with-tail case only shifts.
    always_ff @(posedge clk_line or negedge clk_line_rst) begin
        if (!clk_line_rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            head_valid_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else if (out_pop) begin
            if (tail_valid_reg) begin
                head_reg       <= tail_reg;
                tail_valid_reg <= 1'b0;
            end else if (in_push) begin
                head_reg <= new_beat;
            end else begin
                head_valid_reg <= 1'b0;
            end
        end else if (in_push) begin
            if (!head_valid_reg) begin
                head_reg       <= new_beat;
                head_valid_reg <= 1'b1;
            end else begin
                tail_reg       <= new_beat;
                tail_valid_reg <= 1'b1;
            end
        end
    end

    // Statistics: completed output packets wrap, dropped tuples saturate.
    always_ff @(posedge clk_line or negedge clk_line_rst) begin
        if (!clk_line_rst) begin
            pkt_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (out_pop && head_reg.tlast) begin
                pkt_count_reg <= pkt_count_reg + 1'b1;
            end
            if (tuple_in_VALID && fifo_full && !fifo_pop && (drop_count_reg != '1)) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_p4_tuple_packet_sync.sv
// Directed bench for p4_tuple_packet_sync: alignment, ordering, overflow, enable and reset.
module tb_p4_tuple_packet_sync;
    import p4_sync_pkg::*;

    localparam int DW    = 32;
    localparam int TW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     en;
    logic                     tin_valid;
    logic [TW-1:0]            tin_data;
    logic                     tout_valid;
    logic [TW-1:0]            tout_data;
    logic [CW-1:0]            pkt_cnt;
    logic [CW-1:0]            drop_cnt;
    logic [$clog2(DEPTH):0]   level;

    int compared   = 0;
    int mismatched = 0;

    p4_tuple_packet_sync_if #(.DATA_W(DW)) pin ();
    p4_tuple_packet_sync_if #(.DATA_W(DW)) pout ();

    p4_tuple_packet_sync #(
        .DATA_W(DW), .TUPLE_W(TW), .TUPLE_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk_line          (clk),
        .clk_line_rst      (rst_n),
        .enable_processing (en),
        .packet_in         (pin),
        .packet_out        (pout),
        .tuple_in_VALID    (tin_valid),
        .tuple_in_DATA     (tin_data),
        .tuple_out_VALID   (tout_valid),
        .tuple_out_DATA    (tout_data),
        .pkt_count         (pkt_cnt),
        .tuple_drop_count  (drop_cnt),
        .tuple_fifo_level  (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tuple(input logic [TW-1:0] t);
        tin_valid = 1'b1;
        tin_data  = t;
        step();
        tin_valid = 1'b0;
    endtask

    // Presents one beat and holds it until accepted; returns one step after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        pin.TVALID = 1'b1;
        pin.TDATA  = d;
        pin.TKEEP  = '1;
        pin.TLAST  = last;
        forever begin
            @(negedge clk);
            if (pin.TREADY) break;
            n++;
            if (n > 300) begin
                compared++; mismatched++;
                $display("FAIL send_timeout: beat %0h not accepted, required acceptance", d);
                break;
            end
        end
        step();
        pin.TVALID = 1'b0;
        pin.TLAST  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b0) begin mismatched++; $display("FAIL rst_tready: got %b need 0", pin.TREADY); end
        compared++; if (pout.TVALID !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid: got %b need 0", pout.TVALID); end
        compared++; if (pout.TDATA !== '0) begin mismatched++; $display("FAIL rst_tdata: got %0h need 0", pout.TDATA); end
        compared++; if (tout_valid !== 1'b0) begin mismatched++; $display("FAIL rst_tuple_valid: got %b need 0", tout_valid); end
        compared++; if (pkt_cnt !== '0 || drop_cnt !== '0 || level !== '0) begin
            mismatched++; $display("FAIL rst_counters: got %0d/%0d/%0d need 0/0/0", pkt_cnt, drop_cnt, level); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_alignment();
        tin_valid = 1'b1; tin_data = 16'h00A5;
        pin.TVALID = 1'b1; pin.TDATA = 32'h100; pin.TLAST = 1'b0; pin.TKEEP = '1;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b0) begin mismatched++; $display("FAIL basic_ready_c0: got %b need 0", pin.TREADY); end
        step(); tin_valid = 1'b0;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b1) begin mismatched++; $display("FAIL basic_ready_c1: got %b need 1", pin.TREADY); end
        step(); pin.TDATA = 32'h101;
        @(negedge clk);
        compared++; if (pout.TVALID !== 1'b1 || pout.TDATA !== 32'h100) begin
            mismatched++; $display("FAIL basic_beat0: got v=%b d=%0h need v=1 d=100", pout.TVALID, pout.TDATA); end
        compared++; if (tout_valid !== 1'b1 || tout_data !== 16'h00A5) begin
            mismatched++; $display("FAIL basic_tuple_c2: got v=%b d=%0h need v=1 d=a5", tout_valid, tout_data); end
        step(); pin.TDATA = 32'h102; pin.TLAST = 1'b1;
        @(negedge clk);
        compared++; if (tout_valid !== 1'b0 || pout.TDATA !== 32'h101) begin
            mismatched++; $display("FAIL basic_beat1: got tv=%b d=%0h need tv=0 d=101", tout_valid, pout.TDATA); end
        step(); pin.TVALID = 1'b0; pin.TLAST = 1'b0;
        @(negedge clk);
        compared++; if (tout_valid !== 1'b0 || pout.TDATA !== 32'h102 || pout.TLAST !== 1'b1) begin
            mismatched++; $display("FAIL basic_beat2: got tv=%b d=%0h l=%b need tv=0 d=102 l=1", tout_valid, pout.TDATA, pout.TLAST); end
        step();
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd1 || pout.TVALID !== 1'b0 || tout_data !== 16'h00A5) begin
            mismatched++; $display("FAIL basic_end: got cnt=%0d v=%b td=%0h need cnt=1 v=0 td=a5", pkt_cnt, pout.TVALID, tout_data); end
        step();
    endtask

    task automatic test_packet_before_tuple();
        pin.TVALID = 1'b1; pin.TDATA = 32'h200; pin.TLAST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (pin.TREADY !== 1'b0) begin mismatched++; $display("FAIL early_ready_%0d: got %b need 0", i, pin.TREADY); end
            step();
        end
        tin_valid = 1'b1; tin_data = 16'h0011;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b0) begin mismatched++; $display("FAIL early_ready_push: got %b need 0", pin.TREADY); end
        step(); tin_valid = 1'b0;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b1) begin mismatched++; $display("FAIL early_ready_after: got %b need 1", pin.TREADY); end
        step(); pin.TVALID = 1'b0; pin.TLAST = 1'b0;
        @(negedge clk);
        compared++; if (tout_valid !== 1'b1 || tout_data !== 16'h0011 || pout.TLAST !== 1'b1) begin
            mismatched++; $display("FAIL early_single: got tv=%b td=%0h l=%b need 1/11/1", tout_valid, tout_data, pout.TLAST); end
        step();
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd2 || level !== '0) begin
            mismatched++; $display("FAIL early_cnt: got cnt=%0d lvl=%0d need 2/0", pkt_cnt, level); end
        step();
    endtask

    task automatic test_fifo_overflow();
        for (int i = 0; i < 10; i++) begin
            tin_valid = 1'b1; tin_data = 16'(16'h20 + i);
            step();
        end
        tin_valid = 1'b0;
        @(negedge clk);
        compared++; if (level !== 4'd8) begin mismatched++; $display("FAIL ovf_level: got %0d need 8", level); end
        compared++; if (drop_cnt !== 16'd2) begin mismatched++; $display("FAIL ovf_drops: got %0d need 2", drop_cnt); end
        step();
        tin_valid = 1'b1; tin_data = 16'h0030;
        send_beat(32'h300, 1'b1);
        tin_valid = 1'b0;
        @(negedge clk);
        compared++; if (level !== 4'd8 || drop_cnt !== 16'd2) begin
            mismatched++; $display("FAIL ovf_pushpop: got lvl=%0d drops=%0d need 8/2", level, drop_cnt); end
        compared++; if (tout_valid !== 1'b1 || tout_data !== 16'h0020) begin
            mismatched++; $display("FAIL ovf_first_tuple: got tv=%b td=%0h need 1/20", tout_valid, tout_data); end
        step();
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd3) begin mismatched++; $display("FAIL ovf_cnt: got %0d need 3", pkt_cnt); end
        step();
        do_reset();
    endtask

    task automatic test_backpressure();
        int            lens [20];
        logic [DW-1:0] exp_beats [$];
        bit            exp_sop [$];
        bit            exp_last [$];
        logic [TW-1:0] exp_t [$];
        bit            mon_done;
        mon_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            lens[k] = int'($urandom_range(1, 4));
            exp_t.push_back(16'(16'h40 + k));
            for (int b = 0; b < lens[k]; b++) begin
                exp_beats.push_back(32'(k * 256 + b));
                exp_sop.push_back(b == 0);
                exp_last.push_back(b == lens[k] - 1);
            end
        end
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    push_tuple(16'(16'h40 + k));
                    for (int b = 0; b < lens[k]; b++) begin
                        send_beat(32'(k * 256 + b), b == lens[k] - 1);
                    end
                end
            end
            begin
                while (!mon_done) begin
                    pout.TREADY = 1'($urandom_range(0, 1));
                    step();
                end
            end
            begin
                int got, tc, cyc;
                got = 0; tc = 0; cyc = 0;
                while (got < exp_beats.size() && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (pout.TVALID && pout.TREADY) begin
                        $display("xfer beat %0d data=%0h last=%b tuple_valid=%b tuple=%0h", got, pout.TDATA, pout.TLAST, tout_valid, tout_data);
                        compared++; if (pout.TDATA !== exp_beats[got] || pout.TLAST !== exp_last[got]) begin
                            mismatched++; $display("FAIL bp_beat_%0d: got d=%0h l=%b need d=%0h l=%b", got, pout.TDATA, pout.TLAST, exp_beats[got], exp_last[got]); end
                        compared++; if (tout_valid !== exp_sop[got]) begin
                            mismatched++; $display("FAIL bp_tuple_valid_%0d: got %b need %b", got, tout_valid, exp_sop[got]); end
                        if (exp_sop[got]) begin
                            compared++; if (tout_data !== exp_t[tc]) begin
                                mismatched++; $display("FAIL bp_tuple_%0d: got %0h need %0h", tc, tout_data, exp_t[tc]); end
                            tc++;
                        end
                        got++;
                    end else begin
                        compared++; if (tout_valid !== 1'b0) begin
                            mismatched++; $display("FAIL bp_tuple_idle: got %b need 0", tout_valid); end
                    end
                end
                if (got < exp_beats.size()) begin
                    compared++; mismatched++;
                    $display("FAIL bp_timeout: got %0d beats need %0d", got, exp_beats.size());
                end
                mon_done = 1'b1;
            end
        join
        pout.TREADY = 1'b1;
        step();
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd20 || level !== '0) begin
            mismatched++; $display("FAIL bp_cnt: got cnt=%0d lvl=%0d need 20/0", pkt_cnt, level); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            tin_valid = 1'b1; tin_data = 16'(16'h70 + i);
            step();
        end
        tin_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pin.TVALID = 1'b1; pin.TDATA = 32'(32'h700 + i); pin.TLAST = (i % 2 == 1);
            @(negedge clk);
            compared++; if (pin.TREADY !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_%0d: got %b need 1", i, pin.TREADY); end
            if (i > 0) begin
                compared++; if (tout_valid !== ((i - 1) % 2 == 0)) begin
                    mismatched++; $display("FAIL b2b_tuple_valid_%0d: got %b need %b", i, tout_valid, ((i - 1) % 2 == 0)); end
            end
            step();
        end
        pin.TVALID = 1'b0; pin.TLAST = 1'b0;
        step();
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd23 || level !== '0 || tout_data !== 16'h0072) begin
            mismatched++; $display("FAIL b2b_end: got cnt=%0d lvl=%0d td=%0h need 23/0/72", pkt_cnt, level, tout_data); end
        step();
    endtask

    task automatic test_disable_mid_packet();
        push_tuple(16'h0050);
        push_tuple(16'h0051);
        send_beat(32'h500, 1'b0);
        send_beat(32'h501, 1'b0);
        en = 1'b0;
        pin.TVALID = 1'b1; pin.TDATA = 32'h502; pin.TLAST = 1'b0;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b1) begin mismatched++; $display("FAIL dis_inpkt_ready: got %b need 1", pin.TREADY); end
        step();
        send_beat(32'h503, 1'b1);
        pin.TVALID = 1'b1; pin.TDATA = 32'h510; pin.TLAST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++; if (pin.TREADY !== 1'b0) begin mismatched++; $display("FAIL dis_blocked_%0d: got %b need 0", i, pin.TREADY); end
            step();
        end
        compared++; if (pkt_cnt !== 16'd24 || level !== 4'd1) begin
            mismatched++; $display("FAIL dis_completed: got cnt=%0d lvl=%0d need 24/1", pkt_cnt, level); end
        en = 1'b1;
        @(negedge clk);
        compared++; if (pin.TREADY !== 1'b1) begin mismatched++; $display("FAIL dis_reenable: got %b need 1", pin.TREADY); end
        step(); pin.TVALID = 1'b0; pin.TLAST = 1'b0;
        @(negedge clk);
        compared++; if (tout_valid !== 1'b1 || tout_data !== 16'h0051) begin
            mismatched++; $display("FAIL dis_tuple: got tv=%b td=%0h need 1/51", tout_valid, tout_data); end
        step();
    endtask

    task automatic test_reset_mid_packet();
        push_tuple(16'h0060);
        send_beat(32'h600, 1'b0);
        send_beat(32'h601, 1'b0);
        pin.TVALID = 1'b1; pin.TDATA = 32'h602; pin.TLAST = 1'b0;
        rst_n = 1'b0;
        #1;
        compared++; if (pin.TREADY !== 1'b0 || pout.TVALID !== 1'b0 || pout.TDATA !== '0 || pout.TLAST !== 1'b0) begin
            mismatched++; $display("FAIL mrst_bus: got rdy=%b v=%b d=%0h l=%b need all 0", pin.TREADY, pout.TVALID, pout.TDATA, pout.TLAST); end
        compared++; if (tout_valid !== 1'b0 || tout_data !== '0) begin
            mismatched++; $display("FAIL mrst_tuple: got tv=%b td=%0h need 0/0", tout_valid, tout_data); end
        compared++; if (pkt_cnt !== '0 || level !== '0) begin
            mismatched++; $display("FAIL mrst_counters: got cnt=%0d lvl=%0d need 0/0", pkt_cnt, level); end
        pin.TVALID = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        push_tuple(16'h0061);
        send_beat(32'h610, 1'b0);
        @(negedge clk);
        compared++; if (tout_valid !== 1'b1 || tout_data !== 16'h0061 || pout.TDATA !== 32'h610) begin
            mismatched++; $display("FAIL mrst_new_sop: got tv=%b td=%0h d=%0h need 1/61/610", tout_valid, tout_data, pout.TDATA); end
        step();
        send_beat(32'h611, 1'b1);
        @(negedge clk);
        @(negedge clk);
        compared++; if (pkt_cnt !== 16'd1) begin mismatched++; $display("FAIL mrst_cnt: got %0d need 1", pkt_cnt); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; tin_valid = 1'b0; tin_data = '0;
        pin.TVALID = 1'b0; pin.TDATA = '0; pin.TKEEP = '1; pin.TLAST = 1'b0;
        pout.TREADY = 1'b1;
        step();
        test_reset();
        test_basic_alignment();
        test_packet_before_tuple();
        test_fifo_overflow();
        test_backpressure();
        test_back_to_back();
        test_disable_mid_packet();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
